// File: rtl/mem_dump_pkg.sv
// Shared types and constants for the memory dump unit.
// Optional checksum byte is enabled with MEM_DUMP_CHECKSUM_EN (see mem_dump_unit).
package mem_dump_pkg;

  // Default word geometry of the data RAM
  localparam int DEF_RAM_WIDTH  = 32;
  localparam int BYTES_PER_WORD = DEF_RAM_WIDTH / 8;

  // RAM read latencies: LOW_LATENCY and HIGH_PERFORMANCE configurations
  localparam int LAT_LOW  = 1;
  localparam int LAT_HIGH = 2;

  // Dump sequencer states; ST_CKSUM is only reachable with the checksum option
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SEND  = 3'd3,
    ST_CKSUM = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Number of bits needed to hold 'value' (same rule as the RAM address bus)
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mem_dump_unit_word_serializer.sv
// word_serializer: loads one RAM word and emits it as bytes, MSB first,
// over a valid/ready link. last_byte flags the handshake of the final byte.
module word_serializer
  import mem_dump_pkg::*;
#(
  parameter int WIDTH = DEF_RAM_WIDTH
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             last_byte
);

  localparam int BPW   = WIDTH / 8;
  localparam int IDX_W = (BPW > 1) ? clogb2(BPW - 1) : 1;

  logic [WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  // Current byte is always the top byte of the shift register
  assign out_data  = shift_q[WIDTH-1 -: 8];
  assign out_valid = valid_q;

  // Load a new word, or step to the next byte on each accepted handshake
  always_comb begin
    shift_d   = shift_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    last_byte = 1'b0;
    if (load) begin
      shift_d = din;
      idx_d   = '0;
      valid_d = 1'b1;
    end else if (valid_q && out_ready) begin
      if (idx_q == IDX_W'(BPW - 1)) begin
        valid_d   = 1'b0;
        last_byte = 1'b1;
      end else begin
        shift_d = shift_q << 8;
        idx_d   = idx_q + IDX_W'(1);
      end
    end
  end

  // Serializer registers; reset drops any partially sent word
  always_ff @(posedge clk) begin
    if (srst) begin
      shift_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/mem_dump_unit.sv
// mem_dump_unit: on start, owns the data RAM port, reads words
// [first_addr..last_addr] (inclusive, wrapping at RAM_DEPTH) and streams them
// out MSB-first as bytes. Define MEM_DUMP_CHECKSUM_EN to append an XOR
// checksum byte after the data.
module mem_dump_unit
  import mem_dump_pkg::*;
#(
  parameter int RAM_WIDTH    = DEF_RAM_WIDTH,
  parameter int RAM_DEPTH    = 1024,
  parameter int ADDR_W       = clogb2(RAM_DEPTH - 1),
  parameter int READ_LATENCY = LAT_LOW
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    first_addr,
  input  logic [ADDR_W-1:0]    last_addr,
  output logic                 bus_grant,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic                 ram_regce,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = clogb2((READ_LATENCY > LAT_HIGH) ? READ_LATENCY : LAT_HIGH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(RAM_DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] end_addr_q, end_addr_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;

  logic       ser_load;
  logic       ser_valid;
  logic       ser_last;
  logic [7:0] ser_data;
  logic       last_word;

`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0] cksum_q, cksum_d;
`endif

  assign last_word = (cur_addr_q == end_addr_q);
  // Capture on the edge where the latency counter would reach zero
  assign ser_load  = (state_q == ST_WAIT) && (lat_cnt_q == CNT_W'(LAT_LOW));

  assign ram_addr  = ram_addr_q;
  assign ram_we    = 1'b0;
  assign ram_regce = bus_grant;

  word_serializer #(
    .WIDTH (RAM_WIDTH)
  ) u_ser (
    .clk       (clka),
    .srst      (rsta),
    .load      (ser_load),
    .din       (ram_dout),
    .out_data  (ser_data),
    .out_valid (ser_valid),
    .out_ready (tx_ready),
    .last_byte (ser_last)
  );

  // State register
  always_ff @(posedge clka) begin
    if (rsta) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (ser_load) state_d = ST_SEND;
      ST_SEND: begin
        if (ser_last) begin
          if (last_word) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            state_d = ST_CKSUM;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      ST_CKSUM: if (tx_ready) state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Address range, RAM address, latency counter and checksum updates
  always_comb begin
    cur_addr_d = cur_addr_q;
    end_addr_d = end_addr_q;
    ram_addr_d = ram_addr_q;
    lat_cnt_d  = lat_cnt_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d = first_addr;
          end_addr_d = last_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
          cksum_d    = 8'h00;
`endif
        end
      end
      ST_ISSUE: begin
        ram_addr_d = cur_addr_q;
        lat_cnt_d  = CNT_W'(READ_LATENCY);
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - CNT_W'(1);
      end
      ST_SEND: begin
`ifdef MEM_DUMP_CHECKSUM_EN
        if (ser_valid && tx_ready) cksum_d = cksum_q ^ ser_data;
`endif
        // Wrap explicitly at RAM_DEPTH-1 so non-power-of-2 depths work
        if (ser_last && !last_word) begin
          cur_addr_d = (cur_addr_q == ADDR_MAX) ? '0 : cur_addr_q + ADDR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clka) begin
    if (rsta) begin
      cur_addr_q <= '0;
      end_addr_q <= '0;
      ram_addr_q <= '0;
      lat_cnt_q  <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_q    <= 8'h00;
`endif
    end else begin
      cur_addr_q <= cur_addr_d;
      end_addr_q <= end_addr_d;
      ram_addr_q <= ram_addr_d;
      lat_cnt_q  <= lat_cnt_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  // Outputs decoded from state; byte link comes from the serializer or checksum
  always_comb begin
    busy      = (state_q != ST_IDLE);
    bus_grant = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    tx_valid  = ser_valid;
    tx_data   = ser_data;
`ifdef MEM_DUMP_CHECKSUM_EN
    if (state_q == ST_CKSUM) begin
      tx_valid = 1'b1;
      tx_data  = cksum_q;
    end
`endif
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Testbench for mem_dump_unit: two instances (read latency 1 and 2) share
// one RAM image and one start stream; each has its own RAM timing model,
// tx_ready generator and byte/address scoreboard.
`timescale 1ns/1ps
module tb_mem_dump_unit;
  import mem_dump_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int NI    = 2;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic          clka = 1'b0;
  logic          rsta;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;

  logic          bus_grant_w [NI];
  logic [AW-1:0] ram_addr_w  [NI];
  logic          ram_we_w    [NI];
  logic          ram_regce_w [NI];
  logic [7:0]    tx_data_w   [NI];
  logic          tx_valid_w  [NI];
  logic          busy_w      [NI];
  logic          done_w      [NI];

  logic [W-1:0]  mem [DEPTH];
  logic [7:0]    exp_bytes [$];
  logic [AW-1:0] exp_addr  [$];

  int n_checks   = 0;
  int n_errors   = 0;
  int cyc        = 0;
  int start_cyc  = 0;
  int dump_id    = 0;
  int ready_mode = 0;
  int base0      = 0;
  int base1      = 0;
  bit time_check = 0;

  initial forever #5 clka = ~clka;
  initial forever begin
    @(posedge clka);
    cyc++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int LAT = gi + 1;
    logic         tx_ready   = 1'b0;
    logic [W-1:0] ram_dout   = '0;
    logic [W-1:0] rd_stage   = '0;
    int           ptr        = 0;
    int           my_id      = 0;
    int           done_cnt   = 0;
    bit           seen_valid = 1;
    bit           prev_stall = 0;
    bit           prev_done  = 0;
    bit           toggle     = 0;
    logic [7:0]   prev_data  = '0;

    mem_dump_unit #(
      .RAM_WIDTH    (W),
      .RAM_DEPTH    (DEPTH),
      .ADDR_W       (AW),
      .READ_LATENCY (LAT)
    ) u_dut (
      .clka       (clka),
      .rsta       (rsta),
      .start      (start),
      .first_addr (first_addr),
      .last_addr  (last_addr),
      .bus_grant  (bus_grant_w[gi]),
      .ram_addr   (ram_addr_w[gi]),
      .ram_we     (ram_we_w[gi]),
      .ram_regce  (ram_regce_w[gi]),
      .ram_dout   (ram_dout),
      .tx_data    (tx_data_w[gi]),
      .tx_valid   (tx_valid_w[gi]),
      .tx_ready   (tx_ready),
      .busy       (busy_w[gi]),
      .done       (done_w[gi])
    );

    // RAM model: updates on negedge, data valid LAT posedges after the address
    initial forever begin
      @(negedge clka);
      if (LAT == 1) begin
        ram_dout = mem[ram_addr_w[gi]];
      end else begin
        if (ram_regce_w[gi]) ram_dout = rd_stage;
        rd_stage = mem[ram_addr_w[gi]];
      end
    end

    // Transmitter ready pattern
    initial forever begin
      @(posedge clka);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin
          toggle   = !toggle;
          tx_ready = toggle;
        end
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end

    // Scoreboard: byte order, hold-while-stalled, addresses, done and latency
    initial forever begin
      @(negedge clka);
      if (rsta) begin
        ptr        = 0;
        prev_stall = 0;
        prev_done  = 0;
        seen_valid = 1;
      end else begin
        if (my_id != dump_id) begin
          my_id      = dump_id;
          ptr        = 0;
          seen_valid = 0;
        end
        if (prev_stall) begin
          check_val("hold_valid", tx_valid_w[gi], 1);
          check_val("hold_data", tx_data_w[gi], prev_data);
        end
        if (prev_done) begin
          check_val("done_single", done_w[gi], 0);
          check_val("grant_release", bus_grant_w[gi], 0);
          check_val("busy_release", busy_w[gi], 0);
        end
        if (tx_valid_w[gi] && !seen_valid) begin
          seen_valid = 1;
          check_val("first_valid_lat", cyc - start_cyc, 1 + LAT);
        end
        if (tx_valid_w[gi] && tx_ready) begin
          if (ptr < exp_bytes.size()) check_val("byte", tx_data_w[gi], exp_bytes[ptr]);
          else check_val("extra_byte", ptr, exp_bytes.size());
          if (ptr / BYTES_PER_WORD < exp_addr.size())
            check_val("ram_addr", ram_addr_w[gi], exp_addr[ptr / BYTES_PER_WORD]);
          check_val("grant_regce", {ram_we_w[gi], ram_regce_w[gi], bus_grant_w[gi]}, 3'b011);
          ptr++;
        end
        if (done_w[gi]) begin
          done_cnt++;
          check_val("done_byte_count", ptr, exp_bytes.size());
          if (time_check)
            check_val("dump_latency", cyc - start_cyc,
                      exp_addr.size() * (1 + LAT + BYTES_PER_WORD) + CK);
        end
        prev_stall = tx_valid_w[gi] && !tx_ready;
        prev_data  = tx_data_w[gi];
        prev_done  = done_w[gi];
      end
    end
  end

  task automatic check_outputs_zero();
    for (int k = 0; k < NI; k++) begin
      check_val("rst_bus_grant", bus_grant_w[k], 0);
      check_val("rst_ram_addr", ram_addr_w[k], 0);
      check_val("rst_ram_regce", ram_regce_w[k], 0);
      check_val("rst_ram_we", ram_we_w[k], 0);
      check_val("rst_tx_data", tx_data_w[k], 0);
      check_val("rst_tx_valid", tx_valid_w[k], 0);
      check_val("rst_busy", busy_w[k], 0);
      check_val("rst_done", done_w[k], 0);
    end
  endtask

  // Build the expected byte/address streams and pulse start
  task automatic dump_launch(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode);
    logic [AW-1:0] a;
    logic [W-1:0]  w;
    logic [7:0]    ck;
    exp_bytes.delete();
    exp_addr.delete();
    ck = 8'h00;
    a  = f;
    forever begin
      exp_addr.push_back(a);
      w = mem[a];
      for (int b = BYTES_PER_WORD - 1; b >= 0; b--) begin
        exp_bytes.push_back(w[b*8 +: 8]);
        ck = ck ^ w[b*8 +: 8];
      end
      if (a == l) break;
      a = (int'(a) == DEPTH - 1) ? '0 : a + AW'(1);
    end
    if (CK != 0) exp_bytes.push_back(ck);
    ready_mode = mode;
    time_check = (mode == 0);
    base0 = g_dut[0].done_cnt;
    base1 = g_dut[1].done_cnt;
    @(posedge clka);
    #1;
    start      = 1'b1;
    first_addr = f;
    last_addr  = l;
    dump_id++;
    @(posedge clka);
    #1;
    start      = 1'b0;
    start_cyc  = cyc;
    first_addr = AW'($urandom);
    last_addr  = AW'($urandom);
  endtask

  task automatic dump_wait();
    bit fin;
    fin = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clka);
      #1;
      if (g_dut[0].done_cnt > base0 && g_dut[1].done_cnt > base1) begin
        fin = 1;
        break;
      end
    end
    check_val("dump_finish", fin, 1);
    repeat (2) @(posedge clka);
    #1;
  endtask

  task automatic dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode, input bit mid_start);
    dump_launch(f, l, mode);
    if (mid_start) begin
      repeat (2) @(posedge clka);
      #1;
      start      = 1'b1;
      first_addr = AW'($urandom);
      last_addr  = AW'($urandom);
      @(posedge clka);
      #1;
      start = 1'b0;
    end
    dump_wait();
    $display("dump first=%0d last=%0d words=%0d bytes=%0d ready_mode=%0d mid_start=%0d",
             f, l, exp_addr.size(), exp_bytes.size(), mode, mid_start);
  endtask

  initial begin
    logic [AW-1:0] f;
    logic [AW-1:0] l;
    bit            hit;
    rsta       = 1'b1;
    start      = 1'b0;
    first_addr = '0;
    last_addr  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(posedge clka);
    #1;
    check_outputs_zero();
    rsta = 1'b0;

    mem[5] = 32'h11223344;
    dump(10'd5, 10'd5, 0, 0);

    mem[0] = 32'hA0A1A2A3;
    mem[1] = 32'hB0B1B2B3;
    mem[2] = 32'hC0C1C2C3;
    dump(10'd0, 10'd2, 1, 0);

    mem[1023] = 32'hDEADBEEF;
    mem[0]    = 32'h00000000;
    mem[1]    = 32'h00000001;
    dump(10'd1023, 10'd1, 0, 0);

    mem[3] = 32'h01020304;
    dump(10'd3, 10'd3, 0, 1);

    // Reset in the middle of a 4-word dump, then dump from a new range
    dump_launch(10'd10, 10'd13, 0);
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clka);
      #1;
      if (g_dut[0].ptr >= 2) begin
        hit = 1;
        break;
      end
    end
    check_val("reach_second_byte", hit, 1);
    rsta = 1'b1;
    dump_id++;
    exp_bytes.delete();
    exp_addr.delete();
    @(posedge clka);
    #1;
    check_outputs_zero();
    $display("reset applied mid-dump");
    rsta = 1'b0;
    dump(10'd20, 10'd21, 2, 0);

    for (int n = 0; n < 10; n++) begin
      f = AW'($urandom_range(0, DEPTH - 1));
      l = AW'((int'(f) + $urandom_range(0, 4)) % DEPTH);
      dump(f, l, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
